// File: rtl/fetch_bank_scheduler_pkg.sv
// -----------------------------------------------------------------------------
// fetch_bank_pkg
//
// Shared definitions for the fetch bank scheduler slice: address/data geometry
// of the 8-bank, four-way-read instruction SRAM, the scheduler state encoding,
// and helpers that split a line address into bank and row.
//
// Address layout: bank = addr[2:0], row = addr[ADDR_W-1:3].
// -----------------------------------------------------------------------------
package fetch_bank_pkg;

    localparam int ADDR_W       = 8;
    localparam int DATA_W       = 72;
    localparam int LANES        = 4;
    localparam int BANKS        = 8;
    localparam int BANK_W       = $clog2(BANKS);
    localparam int ROW_W        = ADDR_W - BANK_W;
    localparam int WR_STALL_MAX = 2;
    localparam int STALL_W      = $clog2(WR_STALL_MAX + 1);
    localparam int PASS_W       = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } state_e;

    function automatic logic [BANK_W-1:0] bank_of(input logic [ADDR_W-1:0] addr);
        return addr[BANK_W-1:0];
    endfunction

    function automatic logic [ROW_W-1:0] row_of(input logic [ADDR_W-1:0] addr);
        return addr[ADDR_W-1:BANK_W];
    endfunction

endpackage

// File: rtl/fetch_bank_scheduler_if.sv
// -----------------------------------------------------------------------------
// fetch_bank_scheduler_if
//
// Bundles every non-clock signal of the fetch bank scheduler:
//   request  : i_req_valid / o_req_ready / i_req_addr (lane k at [k*ADDR_W +: ADDR_W])
//   refill   : i_wr_valid / o_wr_ready / i_wr_addr / i_wr_data
//   SRAM     : o_sram_read_en / o_sram_read_addr / o_sram_write_en /
//              o_sram_write_addr / o_sram_write_data / i_sram_datas
//   response : o_rsp_valid / i_rsp_ready / o_rsp_datas / o_rsp_passes
//
// modport slave  : the scheduler side.
// modport master : the surrounding fetch unit / SRAM side.
// -----------------------------------------------------------------------------
interface fetch_bank_scheduler_if;
    import fetch_bank_pkg::*;

    logic                      i_req_valid;
    logic                      o_req_ready;
    logic [LANES*ADDR_W-1:0]   i_req_addr;

    logic                      i_wr_valid;
    logic                      o_wr_ready;
    logic [ADDR_W-1:0]         i_wr_addr;
    logic [DATA_W-1:0]         i_wr_data;

    logic                      o_sram_read_en;
    logic [LANES*ADDR_W-1:0]   o_sram_read_addr;
    logic                      o_sram_write_en;
    logic [ADDR_W-1:0]         o_sram_write_addr;
    logic [DATA_W-1:0]         o_sram_write_data;
    logic [LANES*DATA_W-1:0]   i_sram_datas;

    logic                      o_rsp_valid;
    logic                      i_rsp_ready;
    logic [LANES*DATA_W-1:0]   o_rsp_datas;
    logic [PASS_W-1:0]         o_rsp_passes;

    modport slave (
        input  i_req_valid, i_req_addr,
        input  i_wr_valid, i_wr_addr, i_wr_data,
        input  i_sram_datas, i_rsp_ready,
        output o_req_ready, o_wr_ready,
        output o_sram_read_en, o_sram_read_addr,
        output o_sram_write_en, o_sram_write_addr, o_sram_write_data,
        output o_rsp_valid, o_rsp_datas, o_rsp_passes
    );

    modport master (
        output i_req_valid, i_req_addr,
        output i_wr_valid, i_wr_addr, i_wr_data,
        output i_sram_datas, i_rsp_ready,
        input  o_req_ready, o_wr_ready,
        input  o_sram_read_en, o_sram_read_addr,
        input  o_sram_write_en, o_sram_write_addr, o_sram_write_data,
        input  o_rsp_valid, o_rsp_datas, o_rsp_passes
    );

endinterface

// File: rtl/fetch_bank_scheduler_pass_select.sv
// -----------------------------------------------------------------------------
// fbs_pass_select
//
// Combinational choice of which pending lanes read in the next pass.
// Lanes are walked 0..3: the lowest pending lane is always taken, a later
// pending lane is taken only when no already-taken lane occupies its bank with
// a different address. Taken lanes drive their own address; the rest drive
// the lowest taken lane's address so the SRAM never sees a stray bank access.
//
// Macro FBS_SAME_ROW_MERGE_EN: when defined, same-bank lanes with identical
// addresses share a pass. When undefined, any two lanes in one bank conflict.
//
// Ports:
//   pending    in  LANES         lanes still waiting for data
//   lane_addrs in  LANES*ADDR_W  registered request addresses
//   sel_mask   out LANES         lanes read by this pass
//   rd_addrs   out LANES*ADDR_W  per-lane SRAM read address
// -----------------------------------------------------------------------------
module fbs_pass_select
    import fetch_bank_pkg::*;
(
    input  logic [LANES-1:0]        pending,
    input  logic [LANES*ADDR_W-1:0] lane_addrs,
    output logic [LANES-1:0]        sel_mask,
    output logic [LANES*ADDR_W-1:0] rd_addrs
);

    logic [ADDR_W-1:0] addr_k;
    logic [ADDR_W-1:0] addr_j;
    logic [ADDR_W-1:0] lead_addr;
    logic              conflict;
    logic              found;

    always_comb begin
        sel_mask  = '0;
        lead_addr = lane_addrs[0 +: ADDR_W];
        found     = 1'b0;
        conflict  = 1'b0;
        addr_k    = '0;
        addr_j    = '0;
        for (int k = 0; k < LANES; k++) begin
            addr_k   = lane_addrs[k*ADDR_W +: ADDR_W];
            conflict = 1'b0;
            for (int j = 0; j < k; j++) begin
                addr_j = lane_addrs[j*ADDR_W +: ADDR_W];
                if (sel_mask[j] && (bank_of(addr_j) == bank_of(addr_k))) begin
`ifdef FBS_SAME_ROW_MERGE_EN
                    if (row_of(addr_j) != row_of(addr_k)) begin
                        conflict = 1'b1;
                    end
`else
                    conflict = 1'b1;
`endif
                end
            end
            // The first pending lane sees no earlier selection, so it always issues.
            if (pending[k] && !conflict) begin
                sel_mask[k] = 1'b1;
                if (!found) begin
                    lead_addr = addr_k;
                    found     = 1'b1;
                end
            end
        end
    end

    always_comb begin
        rd_addrs = '0;
        for (int k = 0; k < LANES; k++) begin
            rd_addrs[k*ADDR_W +: ADDR_W] = sel_mask[k] ? lane_addrs[k*ADDR_W +: ADDR_W] : lead_addr;
        end
    end

endmodule

// File: rtl/fetch_bank_scheduler.sv
// -----------------------------------------------------------------------------
// fetch_bank_scheduler
//
// Accepts one 4-lane fetch request, splits it into bank-conflict-free read
// passes on the 8-bank instruction SRAM, and gathers the 72-bit lane words into
// a single response. The refill write port is arbitrated against reads so the
// SRAM is never read and written in the same cycle; a write may stall reads
// for at most WR_STALL_MAX consecutive ISSUE cycles.
//
// Macro FBS_SAME_ROW_MERGE_EN (honoured in fbs_pass_select): identical
// same-bank addresses share a pass when defined.
//
// Ports:
//   i_fire  clock, rising edge
//   rst     asynchronous reset, active low
//   bus     fetch_bank_scheduler_if.slave (request, refill, SRAM, response)
// -----------------------------------------------------------------------------
module fetch_bank_scheduler
    import fetch_bank_pkg::*;
(
    input  logic                   i_fire,
    input  logic                   rst,
    fetch_bank_scheduler_if.slave  bus
);

    state_e                  state;
    state_e                  state_nxt;
    logic [LANES*ADDR_W-1:0] addr_q;
    logic [LANES-1:0]        pending;
    logic [LANES-1:0]        cap_mask;
    logic [LANES-1:0]        sel_mask;
    logic [LANES*ADDR_W-1:0] rd_addrs;
    logic [STALL_W-1:0]      stall_cnt;
    logic [PASS_W-1:0]       passes;
    logic [LANES*DATA_W-1:0] rsp_buf;
    logic                    req_acc;
    logic                    wr_ready;
    logic                    wr_acc;
    logic                    issue;
    logic                    leave_issue;

    fbs_pass_select u_pass_select (
        .pending    (pending),
        .lane_addrs (addr_q),
        .sel_mask   (sel_mask),
        .rd_addrs   (rd_addrs)
    );

    // ---- state register ----
    always_ff @(posedge i_fire or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ---- next-state ----
    // The capture of the final pass lands on the same edge that enters RESP,
    // so only pending needs to be empty to leave ISSUE.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (bus.i_req_valid) state_nxt = ST_ISSUE;
            ST_ISSUE: if (pending == '0)   state_nxt = ST_RESP;
            ST_RESP:  if (bus.i_rsp_ready) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // ---- outputs ----
    // An accepted write always wins the cycle; reads regain it once the
    // stall counter saturates and o_wr_ready drops.
    always_comb begin
        req_acc     = (state == ST_IDLE) && bus.i_req_valid;
        wr_ready    = (state != ST_ISSUE) || (stall_cnt != STALL_W'(WR_STALL_MAX));
        wr_acc      = bus.i_wr_valid && wr_ready;
        issue       = (state == ST_ISSUE) && (pending != '0) && !wr_acc;
        leave_issue = (state == ST_ISSUE) && (state_nxt != ST_ISSUE);

        bus.o_req_ready       = (state == ST_IDLE);
        bus.o_wr_ready        = wr_ready;
        bus.o_sram_read_en    = issue;
        bus.o_sram_read_addr  = rd_addrs;
        bus.o_sram_write_en   = wr_acc;
        bus.o_sram_write_addr = wr_acc ? bus.i_wr_addr : '0;
        bus.o_sram_write_data = wr_acc ? bus.i_wr_data : '0;
        bus.o_rsp_valid       = (state == ST_RESP);
        bus.o_rsp_datas       = rsp_buf;
        bus.o_rsp_passes      = passes;
    end

    // ---- request address capture ----
    always_ff @(posedge i_fire) begin
        if (req_acc) begin
            addr_q <= bus.i_req_addr;
        end
    end

    // ---- pass bookkeeping ----
    always_ff @(posedge i_fire or negedge rst) begin
        if (!rst) begin
            pending   <= '0;
            cap_mask  <= '0;
            stall_cnt <= '0;
            passes    <= '0;
        end else begin
            cap_mask <= issue ? sel_mask : '0;

            if (req_acc) begin
                pending <= '1;
                passes  <= '0;
            end else if (issue) begin
                pending <= pending & ~sel_mask;
                passes  <= passes + PASS_W'(1);
            end

            if (leave_issue || issue) begin
                stall_cnt <= '0;
            end else if ((state == ST_ISSUE) && wr_acc) begin
                stall_cnt <= stall_cnt + STALL_W'(1);
            end
        end
    end

    // ---- capture: SRAM data of the previous cycle's pass ----
    always_ff @(posedge i_fire or negedge rst) begin
        if (!rst) begin
            rsp_buf <= '0;
        end else begin
            for (int k = 0; k < LANES; k++) begin
                if (cap_mask[k]) begin
                    rsp_buf[k*DATA_W +: DATA_W] <= bus.i_sram_datas[k*DATA_W +: DATA_W];
                end
            end
        end
    end

endmodule

// File: doc/fetch_bank_scheduler.md
# fetch_bank_scheduler

Upstream scheduler for the 8-bank, four-way-read instruction SRAM. It accepts one 4-lane fetch request, splits it into bank-conflict-free read passes, and collects the per-lane 72-bit words into one response. It also arbitrates the single refill write port against reads, so the SRAM never sees read and write in the same cycle.

## Interface
- ADDR_W, 8, line address width; bank = addr[2:0], row = addr[ADDR_W-1:3]
- DATA_W, 72, SRAM word width (9 bytes)
- LANES, 4, read lanes per request (fixed at 4)
- WR_STALL_MAX, 2, maximum consecutive ISSUE cycles a write may stall reads
- i_fire  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- i_req_valid  in  1  fetch request valid
- o_req_ready  out  1  request accepted when valid&ready
- i_req_addr  in  LANES*ADDR_W  lane k at [k*ADDR_W+:ADDR_W]
- i_wr_valid  in  1  refill write valid
- o_wr_ready  out  1  refill write accepted
- i_wr_addr  in  ADDR_W  refill address
- i_wr_data  in  DATA_W  refill data
- o_sram_read_en  out  1  SRAM read strobe
- o_sram_read_addr  out  LANES*ADDR_W  per-lane read address
- o_sram_write_en  out  1  SRAM write strobe
- o_sram_write_addr  out  ADDR_W  write address
- o_sram_write_data  out  DATA_W  write data
- i_sram_datas  in  LANES*DATA_W  SRAM output, valid the cycle after o_sram_read_en
- o_rsp_valid  out  1  response valid
- i_rsp_ready  in  1  response consumed when valid&ready
- o_rsp_datas  out  LANES*DATA_W  lane k word at [k*DATA_W+:DATA_W]
- o_rsp_passes  out  3  number of read passes used (1..4)

## Operation
- States: IDLE, ISSUE, RESP.
- IDLE: o_req_ready=1. On accept, register the 4 addresses, set pending=4'b1111, clear passes, go to ISSUE.
- ISSUE pass selection (combinational on pending): walk lanes 0..3; the lowest pending lane is always selected; a later pending lane is selected only if no already-selected lane shares its bank with a different address. Selected lanes drive their own address; unselected lanes drive the lowest selected lane's address. The lowest lane always issues, so at most 4 passes are needed.
- Issuing a pass sets o_sram_read_en=1, clears the selected bits from pending, increments passes, and registers the selected mask as cap_mask.
- Capture: in the cycle after an issue, lanes in cap_mask load i_sram_datas into the response buffer.
- When pending==0 and no capture is outstanding, go to RESP. RESP: o_rsp_valid=1, data and passes held stable; on i_rsp_ready go to IDLE. o_req_ready=0 outside IDLE.
- Write arbitration: o_sram_write_* is i_wr_* passed through, gated by o_wr_ready. o_wr_ready=1 in IDLE and RESP. In ISSUE, o_wr_ready=1 unless stall_cnt==WR_STALL_MAX.
- When a write is accepted during ISSUE, no pass issues, o_sram_read_en=0, and stall_cnt increments. stall_cnt clears on any issued pass and on leaving ISSUE.
- Reads return data as of their issue cycle. A write in the capture cycle does not affect the data captured in that cycle.
- Asserting rst at any point discards the in-flight request and response.

## Timing
- Reset values: state=IDLE, o_req_ready=1, o_wr_ready=1, o_sram_read_en=0, o_sram_write_en=0, o_rsp_valid=0, o_rsp_datas=0, o_rsp_passes=0, pending=0, cap_mask=0, stall_cnt=0.
- Accept on edge E0. Pass p issues in cycle p, with no write stalls. The N-pass request has its final capture at edge E(N+1) and o_rsp_valid=1 from cycle N+2.
- A conflict-free request therefore gives o_rsp_valid 3 cycles after accept. Each accepted write in ISSUE adds 1 cycle.
- A write and a read are never both strobed in the same cycle.

## Configuration
- FBS_SAME_ROW_MERGE_EN defined: same-bank lanes with identical addresses share a pass, as described above.
- Undefined: any two pending lanes in the same bank conflict, even when their addresses are equal. Passes = maximum lanes per bank.

## Structure
- Shared package fetch_bank_pkg: ADDR_W, DATA_W, LANES, BANKS=8, state encoding, and bank_of/row_of functions.
- One sub-module, fbs_pass_select: combinational. Inputs are pending and the 4 addresses; outputs are the selected mask and the 4 driven read addresses. The merge macro is honoured inside it.

## Test plan
- Conflict-free request {0x00,0x01,0x02,0x03} -> one pass, read_en for 1 cycle, o_rsp_valid 3 cycles after accept, passes=1, each lane holds its own word.
- Request {0x08,0x10,0x18,0x20}, all bank 0 with different rows -> 4 passes with lane masks 0001, 0010, 0100, 1000; passes=4; valid 6 cycles after accept.
- Request {0x05,0x05,0x0D,0x06}: with the macro -> 2 passes (mask 1011, then 0100). Without the macro -> 3 passes (1001, 0010, 0100).
- Continuous i_wr_valid during a 4-pass request -> exactly 2 writes accepted, then a forced read pass, repeating. The request completes, and read_en and write_en are never high together.
- Hold i_rsp_ready=0 for 5 cycles -> o_rsp_valid and data stay stable, o_req_ready=0, and a new request is only accepted after the handshake.
- Assert rst in the capture cycle of pass 2 -> all outputs return to their reset values at once. The next request completes normally with fresh data.
